regfile_32x64: RTL and testbench



---
 rtl/cpu_pkg.sv | 6 +
 rtl/decoder5_32.sv | 10 +
 rtl/regfile_32x64.sv | 69 ++++++
 tb/tb_regfile_32x64.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, register-address width and the zero-register index.
package cpu_pkg;
  localparam int WIDTH      = 64;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;
endpackage

// File: rtl/decoder5_32.sv
// 5-bit address to 32-bit one-hot decoder with a global enable.
module decoder5_32 (
  input  logic [4:0]  addr,
  input  logic        en,
  output logic [31:0] onehot
);
  for (genvar gi = 0; gi < 32; gi++) begin : g_dec
    assign onehot[gi] = en && (addr == 5'(gi));
  end
endmodule

// File: rtl/regfile_32x64.sv
// 32x64 architectural register file: two combinational read ports, one synchronous
// write port, X31 hard-wired to zero, and a same-cycle write-to-read bypass.
module regfile_32x64 #(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             RegWrite,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);
  import cpu_pkg::*;

  logic [WIDTH-1:0] regs_reg [NREGS-1];
  logic [WIDTH-1:0] leaf [NREGS];
  logic [NREGS-1:0] wr_onehot;
  logic             wr_en;
  logic [WIDTH-1:0] tree1;
  logic [WIDTH-1:0] tree2;

  // Writes to XZR never reach the decoder, so wr_onehot[31] is always 0.
  assign wr_en = RegWrite && !reset && (WriteRegister != XZR);

  decoder5_32 u_dec (
    .addr   (WriteRegister),
    .en     (wr_en),
    .onehot (wr_onehot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS - 1; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS - 1; i++) begin
        if (wr_onehot[i]) regs_reg[i] <= WriteData;
      end
    end
  end

  for (genvar gi = 0; gi < NREGS - 1; gi++) begin : g_leaf
    assign leaf[gi] = regs_reg[gi];
  end
  assign leaf[NREGS-1] = '0;

  // Binary 2:1 mux tree, least-significant select bit at the leaves.
  function automatic logic [WIDTH-1:0] mux_tree(input logic [WIDTH-1:0] lv [NREGS],
                                                input logic [4:0] sel);
    logic [WIDTH-1:0] stage [NREGS];
    stage = lv;
    for (int l = 0; l < REG_ADDR_W; l++) begin
      for (int k = 0; k < (NREGS >> (l + 1)); k++) begin
        stage[k] = sel[l] ? stage[2*k+1] : stage[2*k];
      end
    end
    return stage[0];
  endfunction

  assign tree1 = mux_tree(leaf, ReadRegister1);
  assign tree2 = mux_tree(leaf, ReadRegister2);

  // The enabled write line for the read address doubles as the bypass select.
  assign ReadData1 = wr_onehot[ReadRegister1] ? WriteData : tree1;
  assign ReadData2 = wr_onehot[ReadRegister2] ? WriteData : tree2;
endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64: directed scenarios plus randomized traffic
// compared every cycle against an array-based register-file model.
module tb_regfile_32x64;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
  logic [63:0] WriteData;
  logic        RegWrite;
  logic [63:0] ReadData1, ReadData2;

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] mem [32];
  bit          model_valid = 1'b0;

  localparam logic [63:0] V5 = 64'h0123_4567_89AB_CDEF;

  regfile_32x64 dut (
    .clk           (clk),
    .reset         (reset),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (!reset && RegWrite && WriteRegister != 5'd31 && WriteRegister == a) return WriteData;
    return mem[a];
  endfunction

  // Model state update on the active edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] = 64'd0;
      model_valid = 1'b1;
    end else if (RegWrite && WriteRegister != 5'd31) begin
      mem[WriteRegister] = WriteData;
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("cyc_rd1", ReadData1, model_read(ReadRegister1));
      check("cyc_rd2", ReadData2, model_read(ReadRegister2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = 5'd0; WriteData = 64'd0;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    tick();
    reset = 1'b0;

    // Reset sweep: every address reads zero on both ports.
    for (int a = 0; a < 32; a++) begin
      ReadRegister1 = 5'(a);
      ReadRegister2 = 5'(31 - a);
      #1;
      check("rst_sweep_rd1", ReadData1, 64'd0);
      check("rst_sweep_rd2", ReadData2, 64'd0);
      tick();
    end

    // Basic write/read.
    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = V5;
    tick();
    RegWrite = 1'b0; ReadRegister1 = 5'd5; ReadRegister2 = 5'd4;
    #1;
    check("wr_x5", ReadData1, V5);
    check("rd_x4", ReadData2, 64'd0);

    // Write to XZR is dropped, reads stay zero.
    RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = '1;
    ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
    #1;
    check("xzr_same_rd1", ReadData1, 64'd0);
    check("xzr_same_rd2", ReadData2, 64'd0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("xzr_after_rd1", ReadData1, 64'd0);
    check("xzr_after_rd2", ReadData2, 64'd0);

    // Bypass on both ports.
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h11;
    tick();
    WriteData = 64'h22; ReadRegister1 = 5'd7; ReadRegister2 = 5'd7;
    #1;
    check("byp_rd1", ReadData1, 64'h22);
    check("byp_rd2", ReadData2, 64'h22);
    tick();
    RegWrite = 1'b0;
    #1;
    check("byp_stored", ReadData1, 64'h22);

    // Write gating, then X30 link write and sweep of the rest.
    RegWrite = 1'b0; WriteRegister = 5'd3; WriteData = 64'hDEAD;
    tick();
    ReadRegister1 = 5'd3;
    #1;
    check("gated_x3", ReadData1, 64'd0);
    RegWrite = 1'b1; WriteRegister = 5'd30; WriteData = 64'hBEEF;
    tick();
    RegWrite = 1'b0; ReadRegister1 = 5'd30;
    for (int a = 0; a < 30; a++) begin
      ReadRegister2 = 5'(a);
      #1;
      check("x30_rd1", ReadData1, 64'hBEEF);
      check("x0_29_rd2", ReadData2, (a == 5) ? V5 : (a == 7) ? 64'h22 : 64'd0);
      tick();
    end

    // Reset wins over a simultaneous write; bypass suppressed.
    reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'h99;
    ReadRegister1 = 5'd9; ReadRegister2 = 5'd5;
    #1;
    check("rstw_byp_rd1", ReadData1, 64'd0);
    check("rstw_old_rd2", ReadData2, V5);
    tick();
    reset = 1'b0; RegWrite = 1'b0;
    #1;
    check("rstw_x9", ReadData1, 64'd0);
    check("rstw_x5", ReadData2, 64'd0);

    // First write after reset lands normally.
    RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'h55;
    tick();
    RegWrite = 1'b0;
    #1;
    check("post_rst_x9", ReadData1, 64'h55);

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 60) == 0);
      RegWrite      = $urandom_range(0, 1) == 1;
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData     = {$urandom, $urandom};
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister2 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      tick();
    end
    reset = 1'b0; RegWrite = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
